uart_receiver: RTL and testbench
================================

# uart_receiver

8N1 UART receiver: the receive-side counterpart of the project's `Transmitter`, sharing its bit timing. It recovers bytes from the serial line `RxD` using mid-bit sampling and a 2-flop input synchronizer. Each good byte is presented on `rx_data` with a one-cycle `rx_valid` strobe; bad stop bits are reported on `frame_err`. It sits in the Tiny Tapeout top, fed from a `uio_in` pin, with `rx_data` driving `uo_out`.

## Interface
- `CLKS_PER_BIT`, default 10416: clock cycles per bit period (100 MHz / 9600 baud). Legal values are 4 and above.
- `clk`  in  1: single clock; all flops on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `RxD`  in  1: serial line. Idle high, LSB first, 1 start bit, 8 data bits, 1 stop bit, no parity. Asynchronous to `clk`.
- `rx_data`  out  8: last correctly framed byte. Held until the next good frame completes.
- `rx_valid`  out  1: one-cycle pulse when `rx_data` updates.
- `frame_err`  out  1: one-cycle pulse when the stop bit samples 0.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- Synchronizer: `RxD` passes through 2 flops, both reset to 1; `rxs` is the second flop. Reset therefore never creates a false start.
- Counters:
  - `cnt` is `$clog2(CLKS_PER_BIT)` bits wide.
  - `HALF = CLKS_PER_BIT/2`, integer division.
  - `bit_idx` is 3 bits.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when `rxs` is 0, go to START and clear `cnt`.
- START: count up. When `cnt == HALF-1`, sample `rxs`.
  - `rxs` = 0: go to DATA, clear `cnt` and `bit_idx`.
  - `rxs` = 1: glitch; return to IDLE with no output activity.
- DATA: count up. When `cnt == CLKS_PER_BIT-1`:
  - Shift `rxs` into the MSB of `shreg` (shift right), clear `cnt`.
  - If `bit_idx == 7`, go to STOP; otherwise increment `bit_idx`.
- STOP: when `cnt == CLKS_PER_BIT-1`, sample `rxs`.
  - `rxs` = 1: `rx_data <= shreg`, pulse `rx_valid`, go to IDLE.
  - `rxs` = 0: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rxs` is 1, then go to IDLE. This covers break conditions: a held-low line yields exactly one `frame_err` and no repeated frames.
- Flow control: none; there is no ready input. The consumer must capture on `rx_valid`. A new frame overwrites `rx_data` only at its own good stop bit.
- Reset, at any time including mid-frame:
  - FSM to IDLE; `cnt`, `bit_idx`, `shreg` cleared.
  - `rx_data` = 0x00, `rx_valid` = 0, `frame_err` = 0, `busy` = 0, synchronizer flops = 1.
  - A partial frame is discarded.

## Timing
- Let t0 be the first cycle in which `rxs` = 0 while in IDLE. `rxs` lags a `RxD` edge by 2 cycles.
- Start-bit check at t0+HALF.
- Data bit k (k = 0..7) is sampled at t0+HALF+(k+1)·CLKS_PER_BIT.
- Stop bit is sampled at t0+HALF+9·CLKS_PER_BIT.
- `rx_valid` or `frame_err` is registered and high during the next cycle only; `rx_data` is valid in that same cycle.
- `busy` rises the cycle after t0 and falls in the same cycle `rx_valid` rises.
- Back-to-back frames: the FSM is back in IDLE about HALF cycles before the stop bit ends, so a start bit arriving immediately after the stop bit is accepted.
- Tolerance: samples are mid-bit, so the receiver accepts roughly ±4% baud mismatch.
- `rx_valid` and `frame_err` are mutually exclusive.

## Test plan
Run with `CLKS_PER_BIT` = 16 and a bench driving ideal 16-cycle bits.
- Reset, then send 0xA5: exactly one `rx_valid` pulse, at t0+8+144+1; `rx_data` = 0xA5; `frame_err` stays 0; `busy` high only during the frame.
- Send 0x00, 0xFF, 0x01 back-to-back with single stop bits: three `rx_valid` pulses, 160 cycles apart, carrying 0x00, 0xFF, 0x01.
- Pull `RxD` low for 5 cycles, then high: `busy` pulses briefly, with no `rx_valid` and no `frame_err`. A following 0x3C frame is received correctly.
- Receive 0x11, then send 0x55 with stop bit 0 and hold the line low for 40 more cycles: one `frame_err` pulse; `rx_data` stays 0x11; FSM stays in WAIT_IDLE until the line goes high. A following 0x7E frame is received correctly.
- Assert `rst_n` low mid-way through the data bits of 0xC3: all outputs 0 immediately. After release with the line idle, a new 0x5A frame is received as 0x5A with no spurious pulse.
- Loopback from `Transmitter` `TxD` into `RxD`, same `CLKS_PER_BIT`, bytes 0x00 to 0xFF: every byte received unchanged; `frame_err` never asserts.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle rx_valid / frame_err strobes.
// rx_data holds the last good byte until the next good stop bit.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RxD,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shreg, shreg_n, data_n;
   logic             valid_n, err_n;
   logic             sync1, rxs;

   // Both stages reset high so leaving reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= RxD;
         rxs   <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_idx_n;
         shreg     <= shreg_n;
         rx_data   <= data_n;
         rx_valid  <= valid_n;
         frame_err <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt + 1'b1;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      data_n    = rx_data;
      valid_n   = 1'b0;
      err_n     = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rxs) state_n = START;
         end
         START: begin
            // A start bit that is high again at its midpoint was a glitch.
            if (cnt == HALF_M1) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               state_n   = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == LAST) begin
               cnt_n   = '0;
               shreg_n = {rxs, shreg[7:1]};
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_idx_n = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (cnt == LAST) begin
               cnt_n = '0;
               if (rxs) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  err_n   = 1'b1;
                  state_n = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            // Held-low line (break) reports one error, then waits for idle.
            cnt_n = '0;
            if (rxs) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frame-level model of expected strobes, held data and busy windows,
// checked every cycle, plus literal checks on latency, data and error counts.
module tb_uart_receiver;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       RxD = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, busy;

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .RxD       (RxD),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   // scoreboard
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   logic [40:0] exp_q[$];   // {cycle, is_err, data}
   int          bq_from[$];
   int          bq_to[$];
   logic [7:0]  model_data = 8'h00;
   bit          model_on = 1'b0;
   logic        exp_v, exp_e, exp_b;
   int          valid_cnt = 0;
   int          err_cnt = 0;
   int          last_valid_cyc = 0;

   always @(negedge clk) begin
      if (rst_n && model_on) begin
         exp_v = 1'b0;
         exp_e = 1'b0;
         if (exp_q.size() > 0 && exp_q[0][40:9] == cyc) begin
            if (exp_q[0][8]) exp_e = 1'b1;
            else begin
               exp_v      = 1'b1;
               model_data = exp_q[0][7:0];
            end
            void'(exp_q.pop_front());
         end
         while (bq_to.size() > 0 && bq_to[0] < cyc) begin
            void'(bq_to.pop_front());
            void'(bq_from.pop_front());
         end
         exp_b = (bq_from.size() > 0 && cyc >= bq_from[0]);
         check("rx_valid", {31'd0, rx_valid}, {31'd0, exp_v});
         check("frame_err", {31'd0, frame_err}, {31'd0, exp_e});
         check("busy", {31'd0, busy}, {31'd0, exp_b});
         check("rx_data", {24'd0, rx_data}, {24'd0, model_data});
         if (rx_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
         end
         if (frame_err) err_cnt++;
      end
   end

   // driver tasks: called and returning at posedge+1
   task automatic idle(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int hold_low);
      int n, t0;
      logic [9:0] bits;
      n    = cyc;
      t0   = n + 2;
      bits = {stop_bit, d, 1'b0};
      exp_q.push_back({32'(t0 + HALF + 9 * CPB + 1), ~stop_bit, stop_bit ? d : 8'h00});
      bq_from.push_back(t0 + 1);
      if (stop_bit) bq_to.push_back(t0 + HALF + 9 * CPB);
      else          bq_to.push_back(n + 10 * CPB + hold_low + 2);
      for (int i = 0; i < 10; i++) begin
         RxD = bits[i];
         idle(CPB);
      end
      if (!stop_bit) begin
         idle(hold_low);
         RxD = 1'b1;
      end
   endtask

   task automatic glitch(input int len);
      int t0;
      t0 = cyc + 2;
      bq_from.push_back(t0 + 1);
      bq_to.push_back(t0 + HALF);
      RxD = 1'b0;
      idle(len);
      RxD = 1'b1;
   endtask

   int s, v0, e0, t0r;
   logic [9:0] pbits;

   initial begin
      rst_n = 1'b0;
      RxD   = 1'b1;
      idle(3);
      check("reset_rx_data", {24'd0, rx_data}, 32'h00);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst_n    = 1'b1;
      model_on = 1'b1;
      idle(4);

      // single frame: pulse at t0+8+144+1 with t0 = drive+2
      s = cyc;
      send_frame(8'hA5, 1'b1, 0);
      idle(4);
      check("a5_latency", last_valid_cyc - s, 32'd155);
      check("a5_data", {24'd0, rx_data}, 32'hA5);
      check("a5_count", valid_cnt, 32'd1);

      // back-to-back, pulses 160 apart
      v0 = valid_cnt;
      s  = cyc;
      send_frame(8'h00, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 0);
      send_frame(8'h01, 1'b1, 0);
      idle(4);
      check("b2b_count", valid_cnt - v0, 32'd3);
      check("b2b_last_latency", last_valid_cyc - s, 32'd475);
      check("b2b_data", {24'd0, rx_data}, 32'h01);

      // short low glitch rejected
      v0 = valid_cnt;
      e0 = err_cnt;
      glitch(5);
      idle(20);
      check("glitch_no_valid", valid_cnt - v0, 32'd0);
      check("glitch_no_err", err_cnt - e0, 32'd0);
      send_frame(8'h3C, 1'b1, 0);
      idle(4);
      check("after_glitch_data", {24'd0, rx_data}, 32'h3C);

      // bad stop bit followed by a held-low line
      send_frame(8'h11, 1'b1, 0);
      idle(4);
      e0 = err_cnt;
      send_frame(8'h55, 1'b0, 40);
      check("wait_idle_busy", {31'd0, busy}, 32'd1);
      idle(5);
      check("wait_idle_exit", {31'd0, busy}, 32'd0);
      check("break_err_count", err_cnt - e0, 32'd1);
      check("break_data_kept", {24'd0, rx_data}, 32'h11);
      idle(11);
      send_frame(8'h7E, 1'b1, 0);
      idle(4);
      check("after_break_data", {24'd0, rx_data}, 32'h7E);

      // reset in the middle of 0xC3's data bits
      t0r   = cyc + 2;
      pbits = {1'b1, 8'hC3, 1'b0};
      bq_from.push_back(t0r + 1);
      bq_to.push_back(t0r + 100000);
      for (int i = 0; i < 5; i++) begin
         RxD = pbits[i];
         idle(CPB);
      end
      idle(3);
      rst_n = 1'b0;
      #1;
      check("midrst_rx_data", {24'd0, rx_data}, 32'h00);
      check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      bq_from.delete();
      bq_to.delete();
      model_data = 8'h00;
      RxD = 1'b1;
      idle(3);
      rst_n = 1'b1;
      v0 = valid_cnt;
      e0 = err_cnt;
      idle(20);
      check("post_rst_quiet", valid_cnt - v0 + err_cnt - e0, 32'd0);
      send_frame(8'h5A, 1'b1, 0);
      idle(4);
      check("post_rst_data", {24'd0, rx_data}, 32'h5A);

      // every byte value with ideal timing
      v0 = valid_cnt;
      e0 = err_cnt;
      for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1, 0);
      idle(4);
      check("sweep_count", valid_cnt - v0, 32'd256);
      check("sweep_no_err", err_cnt - e0, 32'd0);
      check("sweep_last", {24'd0, rx_data}, 32'hFF);
      check("pending_events", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
